// File: rtl/adder_arb_pkg.sv
// Shared types for the round-robin adder-sharing arbiter.
// The subtract option is enabled by defining ADDER_ARB_SUB_EN.
package adder_arb_pkg;
   localparam int ADDER_W  = 64;
   localparam int ID_MAX_W = 3;   // holds any index of up to 8 requesters

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ostage_t;

   typedef struct packed {
      logic [ADDER_W-1:0]  sum;
      logic                cout;
      logic [ID_MAX_W-1:0] id;
   } rsp_t;
endpackage

// File: rtl/cla_64bit.sv
// 64-bit carry-lookahead adder: 4-bit lookahead blocks whose block
// generate/propagate terms feed a block-carry chain.
module cla_64bit
   import adder_arb_pkg::*;
(
   input  logic [ADDER_W-1:0] a,
   input  logic [ADDER_W-1:0] b,
   input  logic               cin,
   output logic [ADDER_W-1:0] sum,
   output logic               cout
);
   localparam int NBLK = ADDER_W / 4;

   logic [ADDER_W-1:0] g;
   logic [ADDER_W-1:0] p;
   logic [ADDER_W-1:0] c;
   logic [NBLK:0]      bc;
   logic               blk_g;
   logic               blk_p;

   always_comb begin
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      bc    = '0;
      blk_g = 1'b0;
      blk_p = 1'b0;
      bc[0] = cin;
      for (int k = 0; k < NBLK; k++) begin
         c[4*k]   = bc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
         blk_g    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         blk_p    = &p[4*k +: 4];
         bc[k+1]  = blk_g | (blk_p & bc[k]);
      end
      sum  = p ^ c;
      cout = bc[NBLK];
   end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);
   localparam int PAD = 2 ** PW;

   logic [PAD-1:0] req_pad;
   logic [PW:0]    pos;

   // Scan from the farthest offset down so the nearest request to ptr wins.
   always_comb begin
      req_pad = PAD'(req);
      idx     = '0;
      any     = 1'b0;
      pos     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (PW+1)'(k);
         if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
         if (req_pad[pos[PW-1:0]]) begin
            idx = pos[PW-1:0];
            any = 1'b1;
         end
      end
      gnt = '0;
      for (int j = 0; j < N; j++) gnt[j] = any & (idx == PW'(j));
   end
endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one cla_64bit among NREQ requesters, with a
// single-entry tagged output register. Define ADDER_ARB_SUB_EN for req_sub.
module adder_share_arb
   import adder_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*ADDER_W-1:0]   req_a,
   input  logic [NREQ*ADDER_W-1:0]   req_b,
   input  logic [NREQ-1:0]           req_cin,
`ifdef ADDER_ARB_SUB_EN
   input  logic [NREQ-1:0]           req_sub,
`endif
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ADDER_W-1:0]        rsp_sum,
   output logic                      rsp_cout,
   output logic [IDW-1:0]            rsp_id,
   output logic [0:0]                state_dbg
);
   localparam logic [0:0] S_EMPTY = EMPTY;
   localparam logic [0:0] S_FULL  = FULL;

   logic [0:0]         state;
   logic [IDW-1:0]     ptr;
   rsp_t               rsp_q;
   logic [NREQ-1:0]    gnt;
   logic [IDW-1:0]     gnt_idx;
   logic               gnt_any;
   logic               can_accept;
   logic               accept;
   logic [ADDER_W-1:0] a_sel;
   logic [ADDER_W-1:0] b_sel;
   logic               cin_sel;
   logic [ADDER_W-1:0] b_eff;
   logic               cin_eff;
   logic [ADDER_W-1:0] add_sum;
   logic               add_cout;
   logic [IDW-1:0]     ptr_next;

   rr_pick #(.N(NREQ), .PW(IDW)) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   // Handshakes: a transfer happens on a cycle where valid & ready are both
   // high. req_ready may depend combinationally on req_valid; rsp_* are
   // held stable while rsp_valid=1 and rsp_ready=0.
   assign can_accept = (state == S_EMPTY) | rsp_ready;
   assign req_ready  = gnt & {NREQ{can_accept & ~rst}};
   assign accept     = gnt_any & can_accept & ~rst;

`ifdef ADDER_ARB_SUB_EN
   logic sub_sel;
`endif

   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
`ifdef ADDER_ARB_SUB_EN
      sub_sel = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            a_sel   = req_a[i*ADDER_W +: ADDER_W];
            b_sel   = req_b[i*ADDER_W +: ADDER_W];
            cin_sel = req_cin[i];
`ifdef ADDER_ARB_SUB_EN
            sub_sel = req_sub[i];
`endif
         end
      end
   end

`ifdef ADDER_ARB_SUB_EN
   // a - b computed as a + ~b + 1; cout=1 then means no borrow.
   assign b_eff   = sub_sel ? ~b_sel : b_sel;
   assign cin_eff = sub_sel ? 1'b1 : cin_sel;
`else
   assign b_eff   = b_sel;
   assign cin_eff = cin_sel;
`endif

   cla_64bit u_add (
      .a    (a_sel),
      .b    (b_eff),
      .cin  (cin_eff),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_EMPTY;
         ptr   <= '0;
         rsp_q <= '0;
      end else if (accept) begin
         state <= S_FULL;
         ptr   <= ptr_next;
         rsp_q <= '{sum: add_sum, cout: add_cout, id: ID_MAX_W'(gnt_idx)};
      end else if ((state == S_FULL) && rsp_ready) begin
         state <= S_EMPTY;
      end
   end

   assign rsp_valid = (state == S_FULL);
   assign rsp_sum   = rsp_q.sum;
   assign rsp_cout  = rsp_q.cout;
   assign rsp_id    = IDW'(rsp_q.id);
   assign state_dbg = state;
endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb (NREQ=4); covers ADDER_ARB_SUB_EN when defined.
module tb_adder_share_arb;
   localparam int NREQ = 4;
   localparam int IDW  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*64-1:0] req_a;
   logic [NREQ*64-1:0] req_b;
   logic [NREQ-1:0]   req_cin;
`ifdef ADDER_ARB_SUB_EN
   logic [NREQ-1:0]   req_sub;
`endif
   logic              rsp_valid;
   logic              rsp_ready;
   logic [63:0]       rsp_sum;
   logic              rsp_cout;
   logic [IDW-1:0]    rsp_id;
   logic [0:0]        state_dbg;

   int errors = 0;
   int checks = 0;
   logic [IDW-1:0] exp_q[$];

   adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
`ifdef ADDER_ARB_SUB_EN
      .req_sub   (req_sub),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic cin);
      req_a[i*64 +: 64] = a;
      req_b[i*64 +: 64] = b;
      req_cin[i]        = cin;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_cin = '0;
`ifdef ADDER_ARB_SUB_EN
      req_sub = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_sum !== 64'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", rsp_sum); end
      checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", rsp_cout); end
      checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      req_valid = '0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_sum !== 64'h0) begin errors++; $display("FAIL single_sum got=%h exp=0", rsp_sum); end
      checks++; if (rsp_cout !== 1'b1) begin errors++; $display("FAIL single_cout got=%b exp=1", rsp_cout); end
      checks++; if (rsp_id !== 3'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
   endtask

   // ptr is 3 here; the only request is 0, so the search must wrap.
   task automatic test_carry();
      set_req(0, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1);
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL carry_ready got=%b exp=0001", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_sum !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL carry_sum got=%h exp=0000000100000000", rsp_sum); end
      checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL carry_cout got=%b exp=0", rsp_cout); end
      checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL carry_id got=%0d exp=0", rsp_id); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      set_req(1, 64'd9, 64'd9, 1'b0);
      req_valid = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ready got=%b exp=0010", req_ready); end
      #2 rst = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready_rst got=%b exp=0000", req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", rsp_valid); end
      rst = 1'b0;
      req_valid = '0;
      @(posedge clk); #1;
      set_req(3, 64'd10, 64'd20, 1'b1);
      req_valid = 4'b1000;
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_next_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_id !== 3'd3) begin errors++; $display("FAIL rmid_next_id got=%0d exp=3", rsp_id); end
      checks++; if (rsp_sum !== 64'd31) begin errors++; $display("FAIL rmid_next_sum got=%h exp=1f", rsp_sum); end
      @(posedge clk); #1;
   endtask

   // ptr is 0 here; five back-to-back accepts leave ptr at 1.
   task automatic test_back_to_back();
      logic [63:0] exp_sum [4];
      logic        exp_cout [4];
      logic [IDW-1:0] id;
      exp_sum[0] = 64'h3;                   exp_cout[0] = 1'b0;
      exp_sum[1] = 64'h1;                   exp_cout[1] = 1'b1;
      exp_sum[2] = 64'h1000;                exp_cout[2] = 1'b0;
      exp_sum[3] = 64'hFFFF_FFFF_FFFF_FFFF; exp_cout[3] = 1'b1;
      set_req(0, 64'h1, 64'h2, 1'b0);
      set_req(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
      set_req(2, 64'h00FF, 64'h0F01, 1'b0);
      set_req(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      req_valid = 4'hF;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_first_ready got=%b exp=0001", req_ready); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         id = exp_q.pop_front();
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, rsp_valid); end
         checks++; if (rsp_id !== id) begin errors++; $display("FAIL b2b_id[%0d] got=%0d exp=%0d", k, rsp_id, id); end
         checks++; if (rsp_sum !== exp_sum[id]) begin errors++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", k, rsp_sum, exp_sum[id]); end
         checks++; if (rsp_cout !== exp_cout[id]) begin errors++; $display("FAIL b2b_cout[%0d] got=%b exp=%b", k, rsp_cout, exp_cout[id]); end
      end
      req_valid = '0;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(1, 64'd100, 64'd23, 1'b0);
      set_req(3, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
      req_valid = 4'b1010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready got=%b exp=0010", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b1000;
      for (int k = 0; k < 5; k++) begin
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", k, req_ready); end
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_sum !== 64'd123)
            begin errors++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/1/7b", k, rsp_valid, rsp_id, rsp_sum); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got=%b exp=1000", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd3) begin errors++; $display("FAIL bp_second got=%b/%0d exp=1/3", rsp_valid, rsp_id); end
      checks++; if (rsp_sum !== 64'h0 || rsp_cout !== 1'b1) begin errors++; $display("FAIL bp_second_sum got=%h/%b exp=0/1", rsp_sum, rsp_cout); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", rsp_valid); end
   endtask

`ifdef ADDER_ARB_SUB_EN
   task automatic test_sub();
      set_req(0, 64'd5, 64'd7, 1'b0);
      req_sub = 4'b0001;
      req_valid = 4'b0001;
      @(posedge clk); #1;
      req_valid = '0;
      req_sub = '0;
      checks++; if (rsp_sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_sum got=%h exp=fffffffffffffffe", rsp_sum); end
      checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL sub_cout got=%b exp=0", rsp_cout); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_carry();
      test_reset_mid();
      test_back_to_back();
      test_backpressure();
`ifdef ADDER_ARB_SUB_EN
      test_sub();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
